// File: rtl/frame_pkg.sv
// ---------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the acquisition frame validator: the framing marker
// words, the default frame length, the validator state encoding and the
// layout of one store-and-forward FIFO entry.
// ---------------------------------------------------------------------------
package frame_pkg;

  localparam int DATA_W              = 32;
  localparam int IDX_W               = 3;   // word index inside a frame
  localparam int ERR_W               = 8;   // saturating error counters
  localparam int FRAME_CNT_W         = 16;  // wrapping committed-frame counter
  localparam int FRAME_WORDS_DEFAULT = 6;   // header, timestamp, 3 payload, footer

  localparam logic [DATA_W-1:0] HEADER_VALUE = 32'hAAAA_AAAA;
  localparam logic [DATA_W-1:0] FOOTER_VALUE = 32'h5555_5555;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // hunting for a header word
    ST_BODY = 2'd1,   // storing a frame that is not yet committed
    ST_DROP = 2'd2    // discarding the rest of a broken frame up to tlast
  } state_e;

  // One FIFO slot: tlast travels with the data word.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/axis_frame_validator_if.sv
// ---------------------------------------------------------------------------
// axis_frame_validator_if
// AXI4-Stream style bundle (tdata/tvalid/tlast/tready) used for both the
// upstream acquisition stream and the validated stream towards the DMA.
//   master modport : drives tdata/tvalid/tlast, samples tready
//   slave  modport : samples tdata/tvalid/tlast, drives tready
// ---------------------------------------------------------------------------
interface axis_frame_validator_if;
  import frame_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/frame_fifo.sv
// ---------------------------------------------------------------------------
// frame_fifo
// Store-and-forward FIFO with three pointers:
//   wr_ptr     - next slot to write (includes the frame being assembled)
//   commit_ptr - end of the last accepted frame; only words below it are
//                visible to the reader
//   rd_ptr     - next slot to present on the read side
// Pointers carry one extra wrap bit so full (2**AW words between wr_ptr and
// rd_ptr) and empty are distinguishable.
// Ports:
//   master_clock, resetn   clock / asynchronous active-low reset
//   wr_en, wr_entry        write one entry at wr_ptr
//   commit                 together with wr_en: accept the frame ending with
//                          this entry (commit_ptr <= wr_ptr + 1)
//   rollback               drop the uncommitted tail (wr_ptr <= commit_ptr)
//   rd_en                  reader accepts the entry at rd_ptr
//   rd_entry, rd_valid     committed entry at rd_ptr (zero when not valid)
//   full                   no free slot for another write
// ---------------------------------------------------------------------------
module frame_fifo
  import frame_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic        master_clock,
  input  logic        resetn,
  input  logic        wr_en,
  input  fifo_entry_t wr_entry,
  input  logic        commit,
  input  logic        rollback,
  input  logic        rd_en,
  output fifo_entry_t rd_entry,
  output logic        rd_valid,
  output logic        full
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] commit_ptr;
  logic [AW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;

  fifo_entry_t mem [DEPTH];

  // Full counts uncommitted words as well: the frame being assembled holds
  // real slots until it is either committed or rolled back.
  assign full     = (wr_ptr - rd_ptr) == PTR_FULL;
  assign rd_valid = (rd_ptr != commit_ptr);
  assign rd_entry = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // A rollback discards the tail, so a write in the same cycle is moot.
  assign do_wr = wr_en & ~full & ~rollback;
  assign do_rd = rd_en & rd_valid;

  always_ff @(posedge master_clock) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_entry;
    end
  end

  // commit_ptr only ever advances, and rollback restores wr_ptr to it, so
  // wr_ptr can never fall below the committed region. Reads only move
  // rd_ptr, so a read in the same cycle as a commit or rollback is safe.
  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      if (rollback) begin
        wr_ptr <= commit_ptr;
      end else if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (commit && do_wr) begin
        commit_ptr <= wr_ptr + PTR_ONE;
      end

      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/axis_frame_validator.sv
// ---------------------------------------------------------------------------
// axis_frame_validator
// Checks fixed-length acquisition frames (header, timestamp, payload, footer)
// arriving on a stream that does not honour backpressure, and forwards only
// complete, well-formed frames to the DMA. Frames are assembled in a
// store-and-forward FIFO and become visible downstream only once the footer
// has been checked; broken frames are rolled back and counted.
// Ports:
//   master_clock       single clock
//   resetn             asynchronous active-low reset
//   s_data (slave)     upstream stream; tready = FIFO not full (advisory)
//   m_data (master)    validated stream; tlast only on footer words
//   frame_count[15:0]  committed frames, wrapping
//   hdr_err[7:0]       non-header words seen while hunting, saturating
//   len_err[7:0]       frames ended early by tlast, saturating
//   ftr_err[7:0]       bad footer value or missing tlast, saturating
//   ovf_err[7:0]       words lost to a full FIFO, saturating
//   dbg_state[1:0]     current validator state (0 idle, 1 body, 2 drop)
// ---------------------------------------------------------------------------
module axis_frame_validator
  import frame_pkg::*;
#(
  parameter int FIFO_AW     = 4,
  parameter int FRAME_WORDS = FRAME_WORDS_DEFAULT
) (
  input  logic                   master_clock,
  input  logic                   resetn,
  axis_frame_validator_if.slave  s_data,
  axis_frame_validator_if.master m_data,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [ERR_W-1:0]       hdr_err,
  output logic [ERR_W-1:0]       len_err,
  output logic [ERR_W-1:0]       ftr_err,
  output logic [ERR_W-1:0]       ovf_err,
  output logic [1:0]             dbg_state
);

  localparam logic [IDX_W-1:0] FOOTER_IDX = IDX_W'(FRAME_WORDS - 1);

  state_e           state;
  state_e           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;

  logic        wr_en;
  logic        commit;
  logic        rollback;
  logic        inc_frame;
  logic        inc_hdr;
  logic        inc_len;
  logic        inc_ftr;
  logic        inc_ovf;

  logic        fifo_full;
  logic        rd_valid;
  fifo_entry_t wr_entry;
  fifo_entry_t rd_entry;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

  // Only committed footers can carry tlast into the FIFO: any earlier word
  // with tlast causes a rollback, so storing the raw tlast is sufficient.
  assign wr_entry = '{last: s_data.tlast, data: s_data.tdata};

  frame_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .master_clock (master_clock),
    .resetn       (resetn),
    .wr_en        (wr_en),
    .wr_entry     (wr_entry),
    .commit       (commit),
    .rollback     (rollback),
    .rd_en        (m_data.tready),
    .rd_entry     (rd_entry),
    .rd_valid     (rd_valid),
    .full         (fifo_full)
  );

  assign m_data.tvalid = rd_valid;
  assign m_data.tdata  = rd_entry.data;
  assign m_data.tlast  = rd_entry.last;
  assign s_data.tready = ~fifo_full;
  assign dbg_state     = state;

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // The source ignores tready, so every valid word is handled in the cycle
  // it arrives; a word that cannot be stored breaks the current frame.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_en     = 1'b0;
    commit    = 1'b0;
    rollback  = 1'b0;
    inc_frame = 1'b0;
    inc_hdr   = 1'b0;
    inc_len   = 1'b0;
    inc_ftr   = 1'b0;
    inc_ovf   = 1'b0;

    if (s_data.tvalid) begin
      unique case (state)
        ST_IDLE: begin
          if (s_data.tdata != HEADER_VALUE) begin
            inc_hdr = 1'b1;
          end else if (fifo_full) begin
            // No room even for the header: lose the whole frame.
            inc_ovf = 1'b1;
            if (!s_data.tlast) state_nxt = ST_DROP;
          end else if (s_data.tlast) begin
            // A header that is also the last word is a one-word frame.
            inc_len = 1'b1;
          end else begin
            wr_en     = 1'b1;
            idx_nxt   = IDX_W'(1);
            state_nxt = ST_BODY;
          end
        end

        ST_BODY: begin
          if (fifo_full) begin
            rollback  = 1'b1;
            inc_ovf   = 1'b1;
            state_nxt = s_data.tlast ? ST_IDLE : ST_DROP;
          end else if (idx == FOOTER_IDX) begin
            if (s_data.tdata == FOOTER_VALUE && s_data.tlast) begin
              wr_en     = 1'b1;
              commit    = 1'b1;
              inc_frame = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              rollback  = 1'b1;
              inc_ftr   = 1'b1;
              state_nxt = s_data.tlast ? ST_IDLE : ST_DROP;
            end
          end else if (s_data.tlast) begin
            rollback  = 1'b1;
            inc_len   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            wr_en   = 1'b1;
            idx_nxt = idx + IDX_W'(1);
          end
        end

        ST_DROP: begin
          if (s_data.tlast) state_nxt = ST_IDLE;
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    if (state_nxt != ST_BODY) idx_nxt = '0;
  end

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      frame_count <= '0;
      hdr_err     <= '0;
      len_err     <= '0;
      ftr_err     <= '0;
      ovf_err     <= '0;
    end else begin
      if (inc_frame) frame_count <= frame_count + FRAME_CNT_W'(1);
      if (inc_hdr)   hdr_err     <= sat_inc(hdr_err);
      if (inc_len)   len_err     <= sat_inc(len_err);
      if (inc_ftr)   ftr_err     <= sat_inc(ftr_err);
      if (inc_ovf)   ovf_err     <= sat_inc(ovf_err);
    end
  end

endmodule

// File: tb/tb_axis_frame_validator.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_validator
// Directed table, hand-written corner sequences and randomized frames for
// axis_frame_validator (FIFO depth 8, 6-word frames). The reference model
// keeps committed words and the frame under assembly as queues.
// ---------------------------------------------------------------------------
module tb_axis_frame_validator;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int FW    = 6;
  localparam logic [31:0] HDR = 32'hAAAAAAAA;
  localparam logic [31:0] FTR = 32'h55555555;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] frame_count;
  logic [7:0]  hdr_err, len_err, ftr_err, ovf_err;
  logic [1:0]  dbg_state;

  axis_frame_validator_if s_if ();
  axis_frame_validator_if m_if ();

  axis_frame_validator #(
    .FIFO_AW     (AW),
    .FRAME_WORDS (FW)
  ) dut (
    .master_clock (clk),
    .resetn       (resetn),
    .s_data       (s_if),
    .m_data       (m_if),
    .frame_count  (frame_count),
    .hdr_err      (hdr_err),
    .len_err      (len_err),
    .ftr_err      (ftr_err),
    .ovf_err      (ovf_err),
    .dbg_state    (dbg_state)
  );

  always #12 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_out  = 0;

  // Reference model state
  logic [32:0] cq[$];   // committed, not yet read: {last, data}
  logic [32:0] pq[$];   // frame under assembly
  bit          dropping;
  int          m_fc, m_hdr, m_len, m_ftr, m_ovf;

  logic [31:0] good_w [FW];

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [15:0] efc;
    logic [7:0]  ehdr;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic l,
                              input logic ev, input logic [31:0] ed, input logic el,
                              input logic [15:0] efc, input logic [7:0] ehdr);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.ev = ev; r.ed = ed; r.el = el;
    r.efc = efc; r.ehdr = ehdr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int sat8(input int x);
    return (x >= 255) ? 255 : x + 1;
  endfunction

  function automatic logic rnd_rdy(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic model_clear();
    cq.delete();
    pq.delete();
    dropping = 0;
    m_fc = 0; m_hdr = 0; m_len = 0; m_ftr = 0; m_ovf = 0;
  endtask

  // One clock edge of the frame rules, in terms of whole-frame bookkeeping.
  task automatic model_step(input logic v, input logic [31:0] d, input logic l,
                            input logic rdy);
    bit full;
    full = (cq.size() + pq.size()) == DEPTH;
    if (rdy && cq.size() > 0) void'(cq.pop_front());
    if (v) begin
      if (dropping) begin
        if (l) dropping = 0;
      end else if (pq.size() == 0) begin
        if (d != HDR)      m_hdr = sat8(m_hdr);
        else if (full)     begin m_ovf = sat8(m_ovf); dropping = !l; end
        else if (l)        m_len = sat8(m_len);
        else               pq.push_back({1'b0, d});
      end else begin
        if (full) begin
          m_ovf = sat8(m_ovf); pq.delete(); dropping = !l;
        end else if (pq.size() == FW - 1) begin
          if (d == FTR && l) begin
            pq.push_back({1'b1, d});
            while (pq.size() > 0) cq.push_back(pq.pop_front());
            m_fc = (m_fc + 1) % 65536;
          end else begin
            m_ftr = sat8(m_ftr); pq.delete(); dropping = !l;
          end
        end else if (l) begin
          m_len = sat8(m_len); pq.delete();
        end else begin
          pq.push_back({1'b0, d});
        end
      end
    end
  endtask

  task automatic check_state();
    int exp_st;
    exp_st = dropping ? 2 : ((pq.size() > 0) ? 1 : 0);
    chk("tvalid", 32'(m_if.tvalid), 32'(cq.size() != 0));
    if (cq.size() != 0) begin
      chk("tdata", m_if.tdata, cq[0][31:0]);
      chk("tlast", 32'(m_if.tlast), 32'(cq[0][32]));
    end
    chk("tready", 32'(s_if.tready), 32'((cq.size() + pq.size()) != DEPTH));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    chk("hdr_err", 32'(hdr_err), 32'(m_hdr));
    chk("len_err", 32'(len_err), 32'(m_len));
    chk("ftr_err", 32'(ftr_err), 32'(m_ftr));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("dbg_state", 32'(dbg_state), 32'(exp_st));
  endtask

  // Inputs are driven 1 unit after posedge; outputs sampled at negedge.
  task automatic step(input logic v, input logic [31:0] d, input logic l, input logic rdy);
    s_if.tvalid = v; s_if.tdata = d; s_if.tlast = l; m_if.tready = rdy;
    @(negedge clk);
    check_state();
    if (m_if.tvalid && rdy) n_out++;
    model_step(v, d, l, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, rdy);
  endtask

  task automatic send_good(input logic rdy);
    for (int i = 0; i < FW; i++) step(1'b1, good_w[i], (i == FW - 1), rdy);
  endtask

  task automatic do_reset();
    s_if.tvalid = 0; s_if.tdata = 0; s_if.tlast = 0; m_if.tready = 0;
    resetn = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] d, input logic l, input int pct);
    while ($urandom_range(0, 3) == 0) step(1'b0, $urandom(), 1'b0, rnd_rdy(pct));
    step(1'b1, d, l, rnd_rdy(pct));
  endtask

  task automatic rand_frame(input int pct);
    int kind;
    int n;
    kind = $urandom_range(0, 5);
    case (kind)
      0: begin
        put(HDR, 0, pct);
        for (int i = 1; i < FW - 1; i++) put($urandom(), 0, pct);
        put(FTR, 1, pct);
      end
      1: put($urandom() | 32'h1, 1'($urandom_range(0, 1)), pct);
      2: begin
        n = $urandom_range(1, FW - 2);
        put(HDR, 0, pct);
        for (int i = 1; i < n; i++) put($urandom(), 0, pct);
        put($urandom(), 1, pct);
      end
      3: begin
        put(HDR, 0, pct);
        for (int i = 1; i < FW - 1; i++) put($urandom(), 0, pct);
        put(FTR ^ (32'h1 << $urandom_range(0, 31)), 1, pct);
      end
      4: begin
        put(HDR, 0, pct);
        for (int i = 1; i < FW - 1; i++) put($urandom(), 0, pct);
        if ($urandom_range(0, 1) == 0) put(FTR, 0, pct);
        else put(FTR ^ (32'h1 << $urandom_range(0, 31)), 0, pct);
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) put($urandom() | 32'h1, 0, pct);
        put($urandom() | 32'h1, 1, pct);
      end
      default: idle($urandom_range(1, 6), rnd_rdy(pct));
    endcase
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, fc0;
    good_w[0] = 32'hAAAAAAAA; good_w[1] = 32'h00000010; good_w[2] = 32'hDDDDDDDD;
    good_w[3] = 32'hCCCCCCCC; good_w[4] = 32'h0BBBBBBB; good_w[5] = 32'h55555555;

    // Good frame, junk word, good frame, then drain (tready held high).
    tbl[0]  = mk(1, 32'hAAAAAAAA, 0, 0, 32'h0,        0, 0, 0);
    tbl[1]  = mk(1, 32'h00000010, 0, 0, 32'h0,        0, 0, 0);
    tbl[2]  = mk(1, 32'hDDDDDDDD, 0, 0, 32'h0,        0, 0, 0);
    tbl[3]  = mk(1, 32'hCCCCCCCC, 0, 0, 32'h0,        0, 0, 0);
    tbl[4]  = mk(1, 32'h0BBBBBBB, 0, 0, 32'h0,        0, 0, 0);
    tbl[5]  = mk(1, 32'h55555555, 1, 0, 32'h0,        0, 0, 0);
    tbl[6]  = mk(1, 32'h12345678, 0, 1, 32'hAAAAAAAA, 0, 1, 0);
    tbl[7]  = mk(1, 32'hAAAAAAAA, 0, 1, 32'h00000010, 0, 1, 1);
    tbl[8]  = mk(1, 32'h00000010, 0, 1, 32'hDDDDDDDD, 0, 1, 1);
    tbl[9]  = mk(1, 32'hDDDDDDDD, 0, 1, 32'hCCCCCCCC, 0, 1, 1);
    tbl[10] = mk(1, 32'hCCCCCCCC, 0, 1, 32'h0BBBBBBB, 0, 1, 1);
    tbl[11] = mk(1, 32'h0BBBBBBB, 0, 1, 32'h55555555, 1, 1, 1);
    tbl[12] = mk(1, 32'h55555555, 1, 0, 32'h0,        0, 1, 1);
    tbl[13] = mk(0, 32'h0,        0, 1, 32'hAAAAAAAA, 0, 2, 1);
    tbl[14] = mk(0, 32'h0,        0, 1, 32'h00000010, 0, 2, 1);
    tbl[15] = mk(0, 32'h0,        0, 1, 32'hDDDDDDDD, 0, 2, 1);
    tbl[16] = mk(0, 32'h0,        0, 1, 32'hCCCCCCCC, 0, 2, 1);
    tbl[17] = mk(0, 32'h0,        0, 1, 32'h0BBBBBBB, 0, 2, 1);
    tbl[18] = mk(0, 32'h0,        0, 1, 32'h55555555, 1, 2, 1);
    tbl[19] = mk(0, 32'h0,        0, 0, 32'h0,        0, 2, 1);

    // Reset state
    s_if.tvalid = 0; s_if.tdata = 0; s_if.tlast = 0; m_if.tready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_tready", 32'(s_if.tready), 32'd1);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_errs", {hdr_err, len_err, ftr_err, ovf_err}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    resetn = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      s_if.tvalid = tbl[i].v; s_if.tdata = tbl[i].d; s_if.tlast = tbl[i].l;
      m_if.tready = 1;
      @(negedge clk);
      chk("tbl_tvalid", 32'(m_if.tvalid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("tbl_tdata", m_if.tdata, tbl[i].ed);
        chk("tbl_tlast", 32'(m_if.tlast), 32'(tbl[i].el));
      end
      chk("tbl_frame_count", 32'(frame_count), 32'(tbl[i].efc));
      chk("tbl_hdr_err", 32'(hdr_err), 32'(tbl[i].ehdr));
      @(posedge clk);
      #1;
    end

    // Early tlast, then a good frame still passes.
    do_reset();
    n0 = n_out;
    step(1, HDR, 0, 1); step(1, 32'h1, 0, 1); step(1, 32'h2, 0, 1); step(1, 32'h3, 1, 1);
    idle(3, 1);
    chk("short_len_err", 32'(len_err), 32'd1);
    chk("short_no_output", 32'(n_out - n0), 32'd0);
    send_good(1);
    idle(8, 1);
    chk("short_next_out", 32'(n_out - n0), 32'd6);
    chk("short_next_fc", 32'(frame_count), 32'd1);

    // Bad footer without tlast, junk, junk with tlast.
    n0 = n_out;
    for (int i = 0; i < FW - 1; i++) step(1, good_w[i], 0, 1);
    step(1, 32'h55555554, 0, 1);
    step(1, 32'h11111111, 0, 1);
    step(1, 32'h22222222, 1, 1);
    idle(3, 1);
    chk("ftr_err", 32'(ftr_err), 32'd1);
    chk("ftr_no_output", 32'(n_out - n0), 32'd0);
    chk("ftr_state_idle", 32'(dbg_state), 32'd0);

    // Two frames into a depth-8 FIFO with the reader stalled.
    n0 = n_out;
    fc0 = int'(frame_count);
    send_good(0);
    send_good(0);
    idle(2, 0);
    chk("ovf_err", 32'(ovf_err), 32'd1);
    chk("ovf_fc", 32'(frame_count), 32'(fc0 + 1));
    idle(10, 1);
    chk("ovf_drain", 32'(n_out - n0), 32'd6);

    // Asynchronous reset mid-frame with a committed frame waiting.
    send_good(0);
    step(1, HDR, 0, 0); step(1, 32'h00000010, 0, 0); step(1, 32'hDDDDDDDD, 0, 0);
    chk("pre_rst_tvalid", 32'(m_if.tvalid), 32'd1);
    s_if.tvalid = 1; s_if.tdata = 32'hCCCCCCCC; s_if.tlast = 0;
    #5;
    resetn = 0;
    #1;
    chk("arst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("arst_tdata", m_if.tdata, 32'd0);
    chk("arst_tlast", 32'(m_if.tlast), 32'd0);
    chk("arst_tready", 32'(s_if.tready), 32'd1);
    chk("arst_frame_count", 32'(frame_count), 32'd0);
    chk("arst_errs", {hdr_err, len_err, ftr_err, ovf_err}, 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    s_if.tvalid = 0;
    @(negedge clk);
    resetn = 1;
    @(posedge clk);
    #1;
    n0 = n_out;
    send_good(1);
    idle(8, 1);
    chk("post_rst_fc", 32'(frame_count), 32'd1);
    chk("post_rst_out", 32'(n_out - n0), 32'd6);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) step(1, 32'h12345679, 0, 1);
    idle(1, 1);
    chk("hdr_err_sat", 32'(hdr_err), 32'd255);

    // Randomized frames with varying reader stall rates.
    do_reset();
    for (int f = 0; f < 250; f++) begin
      int pct;
      case ($urandom_range(0, 2))
        0: pct = 10;
        1: pct = 50;
        default: pct = 95;
      endcase
      rand_frame(pct);
    end
    idle(2 * DEPTH + 4, 1);
    chk("final_empty", 32'(m_if.tvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_frame_validator.md
AXIS_FRAME_VALIDATOR -- requirements
Module: axis_frame_validator

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, meaning FIFO depth 2**FIFO_AW 32-bit words.
REQ-002 SHALL have parameter FRAME_WORDS, default 6, meaning words per frame: header, timestamp, 3 payload, footer.
REQ-003 SHALL have port master_clock, input, 1 bit: single clock, 40 MHz.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports s_data_tdata / s_data_tvalid / s_data_tlast, input, 32/1/1 bits: upstream acquisition stream.
REQ-006 SHALL have port s_data_tready, output, 1 bit: high when FIFO not full.
REQ-007 SHALL have ports m_data_tdata / m_data_tvalid / m_data_tlast, output, 32/1/1 bits: validated stream to DMA.
REQ-008 SHALL have port m_data_tready, input, 1 bit: downstream accept.
REQ-009 SHALL have port frame_count, output, 16 bits: committed frames, wrapping.
REQ-010 SHALL have ports hdr_err, len_err, ftr_err and ovf_err, output, 8 bits each: saturating error counters.
REQ-011 SHALL have port dbg_state, output, 2 bits: current FSM state.

Function
REQ-012 SHALL accept an input word on every cycle with s_data_tvalid=1; the upstream source does not honour tready.
REQ-013 SHALL implement a store-and-forward FIFO with wr_ptr, commit_ptr and rd_ptr; each entry is {tlast, tdata}.
REQ-014 SHALL run FSM IDLE(0) / BODY(1) / DROP(2); word index is a 3-bit counter.
REQ-015 IDLE: on a 32'hAAAAAAAA word, SHALL write it, set the index to 1 and go to BODY; any other word is discarded with hdr_err+1 and the FSM stays in IDLE.
REQ-016 BODY: SHALL write each word and increment the index; index FRAME_WORDS-1 is the footer position.
REQ-017 BODY: tlast at index < FRAME_WORDS-1 SHALL roll wr_ptr back to commit_ptr, increment len_err and return to IDLE.
REQ-018 BODY, footer position: 32'h55555555 with tlast SHALL set commit_ptr=wr_ptr+1, increment frame_count and return to IDLE.
REQ-019 BODY, footer position, wrong value with tlast: SHALL roll back, increment ftr_err and return to IDLE.
REQ-020 BODY, footer position, wrong value without tlast: SHALL roll back, increment ftr_err and go to DROP.
REQ-021 A word arriving while the FIFO is full in BODY SHALL cause rollback, ovf_err+1, and a transition to DROP (or to IDLE if that word has tlast).
REQ-022 DROP: SHALL discard words until one with tlast, then go to IDLE.
REQ-023 Output: m_data_tvalid SHALL equal (rd_ptr != commit_ptr); tdata/tlast come from the entry at rd_ptr; rd_ptr advances when tvalid and tready are both high.
REQ-024 A committed frame SHALL present its first word on m_data_tvalid in the cycle after the commit edge; uncommitted words are never visible.
REQ-025 Simultaneous read and commit or rollback SHALL be legal; rollback never moves wr_ptr below commit_ptr.
REQ-026 Full SHALL be computed as wr_ptr - rd_ptr == 2**FIFO_AW, using FIFO_AW+1-bit pointers.
REQ-027 Error counters SHALL saturate at 255; frame_count SHALL wrap at 65535.
REQ-028 m_data_tlast SHALL be set only on footer entries.

Reset
REQ-029 resetn low SHALL asynchronously clear all pointers, counters and the index, set state to IDLE, and drive m_data_tvalid=0, s_data_tready=1 and all counter outputs to 0.
REQ-030 Reset mid-frame SHALL discard the partial frame and all uncommitted and committed FIFO contents.

Structure
REQ-031 Package frame_pkg SHALL hold HEADER_VALUE, FOOTER_VALUE, FRAME_WORDS default and the state encoding.
REQ-032 Sub-module frame_fifo SHALL implement the memory, the three pointers, and the commit/rollback ports; the FSM and counters stay in the top module.

Verification
REQ-033 Send one good frame {AAAAAAAA, 00000010, DDDDDDDD, CCCCCCCC, 0BBBBBBB, 55555555+tlast} with m_data_tready=1 -> 6 words out in order, tlast on the 6th, frame_count=1.
REQ-034 Send 12345678 then a good frame -> hdr_err=1 and the good frame is delivered intact.
REQ-035 Send a frame with tlast on word 4 -> len_err=1, nothing output, and the next good frame passes.
REQ-036 Send a frame with footer 55555554 and no tlast, then 2 junk words, the second with tlast -> ftr_err=1, no output, FSM in IDLE afterwards.
REQ-037 Hold m_data_tready=0 with FIFO_AW=3 and send 2 frames -> first frame committed, second overflows, ovf_err=1; after tready=1, exactly 6 words drain.
REQ-038 Assert resetn=0 at word 3 of a frame -> all outputs 0 asynchronously, and after release the next good frame passes with frame_count=1.
